// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select and load-use stall generation, driven by a shadow
// pipeline of register-tag metadata that advances with the main pipeline.

module fwd_sel #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_we,
  output logic [1:0]            sel
);
  // The most recent producer wins; x0 is hardwired and never forwards.
  always_comb begin
    sel = 2'b00;
    if (mem_we && mem_rd != '0 && mem_rd == ex_rs)
      sel = 2'b10;
    else if (wb_we && wb_rd != '0 && wb_rd == ex_rs)
      sel = 2'b01;
  end
endmodule

module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   id_regWrite,
  input  logic                   id_memRead,
  input  logic                   flush,
  output logic [1:0]             forwardA,
  output logic [1:0]             forwardB,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_count
);
  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  mr;
  } ex_stage_t;

  ex_stage_t             ex_q, ex_d;
  logic [REG_ADDR_W-1:0] mem_rd, wb_rd;
  logic                  mem_we, mem_mr, wb_we;

  logic [NUM_OPS-1:0][REG_ADDR_W-1:0] ex_rs;
  logic [NUM_OPS-1:0][1:0]            fwd;

  assign stall = !flush && id_valid && ex_q.mr && ex_q.we && ex_q.rd != '0 &&
                 (ex_q.rd == id_rs1 || ex_q.rd == id_rs2);

  // Flush and stall both turn the EX slot into a bubble.
  always_comb begin
    ex_d = '0;
    if (!flush && !stall && id_valid) begin
      ex_d.rs1 = id_rs1;
      ex_d.rs2 = id_rs2;
      ex_d.rd  = id_rd;
      ex_d.we  = id_regWrite;
      ex_d.mr  = id_memRead;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= '0;
      mem_rd      <= '0;
      mem_we      <= 1'b0;
      mem_mr      <= 1'b0;
      wb_rd       <= '0;
      wb_we       <= 1'b0;
      stall_count <= '0;
    end else begin
      ex_q   <= ex_d;
      mem_rd <= ex_q.rd;
      mem_we <= ex_q.we;
      mem_mr <= ex_q.mr;
      wb_rd  <= mem_rd;
      wb_we  <= mem_we;
      if (stall && stall_count != '1)
        stall_count <= stall_count + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign ex_rs = {ex_q.rs2, ex_q.rs1};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel (
      .ex_rs  (ex_rs[g]),
      .mem_rd (mem_rd),
      .mem_we (mem_we),
      .wb_rd  (wb_rd),
      .wb_we  (wb_we),
      .sel    (fwd[g])
    );
  end

  assign forwardA = fwd[0];
  assign forwardB = fwd[1];

  // A load never reaches MEM ahead of a dependent EX op: the stall sits between them.
  a_no_load_exmem_fwd: assert property (@(posedge clk) disable iff (reset)
    !(mem_mr && (forwardA == 2'b10 || forwardB == 2'b10)));
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: expected selects queued per issue slot,
// checked when that slot occupies EX; stall checked combinationally.

module tb_fwd_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_regWrite, id_memRead, flush;
  logic [1:0]    forwardA, forwardB;
  logic          stall;
  logic [CW-1:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [CW-1:0] exp_cnt;
  logic [3:0]    sb[$];

  fwd_hazard_ctrl #(.REG_ADDR_W(AW), .STALL_CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_regWrite(id_regWrite),
    .id_memRead(id_memRead), .flush(flush), .forwardA(forwardA),
    .forwardB(forwardB), .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_regWrite = 0; id_memRead = 0; flush = 0;
  endtask

  // One issue slot: check what entered EX at this edge, drive the new ID
  // fields, check stall, and queue the selects expected once this slot is in EX.
  task automatic step(input logic v, input logic [AW-1:0] rs1, rs2, rd,
                      input logic we, mr, fl, input logic est,
                      input logic [1:0] efa, efb);
    logic [3:0] e;
    @(posedge clk); #1;
    if (sb.size() == 0) chk("sb_underflow", 1, 0);
    else begin
      e = sb.pop_front();
      chk("forwardA", 32'(forwardA), 32'(e[3:2]));
      chk("forwardB", 32'(forwardB), 32'(e[1:0]));
    end
    chk("stall_count", 32'(stall_count), 32'(exp_cnt));
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_regWrite = we; id_memRead = mr; flush = fl;
    #1;
    chk("stall", 32'(stall), 32'(est));
    if (est && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    sb.push_back({efa, efb});
  endtask

  initial begin
    logic [3:0] e;
    idle();
    reset = 1'b1;
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_forwardA", 32'(forwardA), 0);
    chk("rst_forwardB", 32'(forwardB), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_count", 32'(stall_count), 0);
    reset = 1'b0;
    sb.push_back(4'b0000);

    // ALU chain: add x5 then sub rs1=5
    step(1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00);
    step(1, 5, 6, 8, 1, 0, 0, 0, 2'b10, 2'b00);
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);

    // distance two -> WB forward, then two producers -> MEM wins
    step(1, 3, 4, 7, 1, 0, 0, 0, 2'b00, 2'b00);
    step(1, 3, 4, 9, 1, 0, 0, 0, 2'b00, 2'b00);
    step(1, 3, 7, 10, 1, 0, 0, 0, 2'b00, 2'b01);
    step(1, 3, 4, 7, 1, 0, 0, 0, 2'b00, 2'b00);
    step(1, 3, 4, 7, 1, 0, 0, 0, 2'b00, 2'b00);
    step(1, 6, 7, 10, 1, 0, 0, 0, 2'b00, 2'b10);

    // load-use: one stall, bubble, then WB forward
    step(1, 6, 9, 3, 1, 1, 0, 0, 2'b00, 2'b00);
    step(1, 3, 4, 11, 1, 0, 0, 1, 2'b00, 2'b00);
    step(1, 3, 4, 11, 1, 0, 0, 0, 2'b01, 2'b00);
    step(1, 6, 9, 12, 1, 1, 0, 0, 2'b00, 2'b00);
    step(1, 4, 5, 13, 1, 0, 0, 0, 2'b00, 2'b00); // independent op after load

    // x0 guard
    step(1, 6, 9, 0, 1, 0, 0, 0, 2'b00, 2'b00);
    step(1, 0, 0, 14, 1, 0, 0, 0, 2'b00, 2'b00);
    step(1, 6, 9, 0, 1, 1, 0, 0, 2'b00, 2'b00);
    step(1, 0, 0, 15, 1, 0, 0, 0, 2'b00, 2'b00);

    // flush beats load-use stall; flushed slot must not forward
    step(1, 6, 9, 4, 1, 1, 0, 0, 2'b00, 2'b00);
    step(1, 6, 4, 16, 1, 0, 1, 0, 2'b00, 2'b00);
    step(1, 16, 17, 18, 1, 0, 0, 0, 2'b00, 2'b00);
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);

    // reset mid-stream while forwardA=10
    step(1, 6, 9, 5, 1, 0, 0, 0, 2'b00, 2'b00);
    step(1, 5, 6, 8, 1, 0, 0, 0, 2'b10, 2'b00);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("pre_rst_forwardA", 32'(forwardA), 32'(e[3:2]));
    idle();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_forwardA", 32'(forwardA), 0);
    chk("async_rst_forwardB", 32'(forwardB), 0);
    chk("async_rst_stall", 32'(stall), 0);
    chk("async_rst_count", 32'(stall_count), 0);
    #2 reset = 1'b0;
    exp_cnt = '0;
    sb.delete();
    sb.push_back(4'b0000);
    step(1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00);
    step(1, 5, 6, 8, 1, 0, 0, 0, 2'b10, 2'b00);

    // counter saturation: 2^CW+3 load-use stalls
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      step(1, 6, 9, 3, 1, 1, 0, 0, 2'b00, 2'b00);
      step(1, 3, 4, 11, 1, 0, 0, 1, 2'b00, 2'b00);
      step(1, 3, 4, 11, 1, 0, 0, 0, 2'b01, 2'b00);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    chk("count_saturated", 32'(stall_count), 32'({CW{1'b1}}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
